// File: rtl/clk_wave_meas.sv
`default_nettype none
// ============================================================================
// Module      : clk_wave_meas
// Description : Synchronises an asynchronous periodic signal and measures, in
//               clk cycles, its phase from a start pulse, its high time, low
//               time and period. Flags counter overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_wave_meas #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    output logic [CNT_W-1:0] phase,
    output logic             phase_vld,
    output logic [CNT_W-1:0] ton,
    output logic [CNT_W-1:0] toff,
    output logic [CNT_W:0]   period,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] c_ST_HIGH      = 2'd2;
    localparam logic [1:0] c_ST_LOW       = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cnt_max;
    logic                   w_term;
    logic                   w_ovf;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_phase;
    logic [CNT_W-1:0]       r_ton;
    logic [CNT_W-1:0]       r_toff;
    logic [CNT_W:0]         r_period;
    logic                   r_phase_vld;
    logic                   r_valid;
    logic                   r_err;

    // Synchroniser chain followed by a one-flop edge-detect register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise    =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_fall    = ~r_sync[SYNC_STAGES-1] &  r_prev;
    assign w_cnt_max = (r_cnt == c_CNT_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start beats any edge, the terminating edge beats overflow
    always_comb begin
        w_state_nxt = r_state;
        w_term      = 1'b0;
        case (r_state)
            c_ST_WAIT_RISE: w_term = w_rise;
            c_ST_HIGH:      w_term = w_fall;
            c_ST_LOW:       w_term = w_rise;
            default:        w_term = 1'b0;
        endcase
        w_ovf = (r_state != c_ST_IDLE) && !start && !w_term && w_cnt_max;
        if (start) begin
            w_state_nxt = c_ST_WAIT_RISE;
        end else if (w_term) begin
            w_state_nxt = (r_state == c_ST_HIGH) ? c_ST_LOW : c_ST_HIGH;
        end else if (w_ovf) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Counter and result registers; results hold until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_phase     <= '0;
            r_ton       <= '0;
            r_toff      <= '0;
            r_period    <= '0;
            r_phase_vld <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (start) begin
                r_cnt       <= c_CNT_ONE;
                r_phase_vld <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_term) begin
                r_cnt <= c_CNT_ONE;
                case (r_state)
                    c_ST_WAIT_RISE: begin
                        r_phase     <= r_cnt;
                        r_phase_vld <= 1'b1;
                    end
                    c_ST_HIGH: begin
                        r_ton <= r_cnt;
                    end
                    c_ST_LOW: begin
                        r_toff   <= r_cnt;
                        r_period <= {1'b0, r_ton} + {1'b0, r_cnt};
                        r_valid  <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else if (w_ovf) begin
                r_err <= 1'b1;
            end else if (r_state != c_ST_IDLE) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign phase     = r_phase;
    assign phase_vld = r_phase_vld;
    assign ton       = r_ton;
    assign toff      = r_toff;
    assign period    = r_period;
    assign valid     = r_valid;
    assign busy      = (r_state != c_ST_IDLE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_wave_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_wave_meas
// Description : Self-checking bench for clk_wave_meas. Two instances (16-bit
//               and 4-bit counters) share stimulus; a timestamp-based model
//               predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_wave_meas;

    localparam int N      = 2;
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_HIGH = 2;
    localparam int M_LOW  = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sig_in;

    logic [15:0] phase16, ton16, toff16;
    logic [16:0] period16;
    logic        phase_vld16, valid16, busy16, err16;
    logic [3:0]  phase4, ton4, toff4;
    logic [4:0]  period4;
    logic        phase_vld4, valid4, busy4, err4;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int rst_edge = -100;
    bit chk_en   = 1'b0;
    bit rnd_mode = 1'b0;
    bit hist [64];

    // Model: per instance, mode plus the edge index of the last reference event
    int md [2];
    int tref [2];
    int m_phase [2];
    int m_pv [2];
    int m_ton [2];
    int m_toff [2];
    int m_per [2];
    int m_val [2];
    int m_err [2];
    int maxc [2] = '{65535, 15};

    int q16 [$];
    int pv16_edge = -1;
    bit pv16_prev = 1'b0;

    clk_wave_meas #(.CNT_W(16), .SYNC_STAGES(N)) dut16 (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
        .phase(phase16), .phase_vld(phase_vld16), .ton(ton16), .toff(toff16),
        .period(period16), .valid(valid16), .busy(busy16), .err(err16)
    );

    clk_wave_meas #(.CNT_W(4), .SYNC_STAGES(N)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
        .phase(phase4), .phase_vld(phase_vld4), .ton(ton4), .toff(toff4),
        .period(period4), .valid(valid4), .busy(busy4), .err(err4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Level of sig_in as seen by the synchroniser at edge j (reset clears it)
    function automatic bit samp(input int j);
        if (j < 1 || j <= rst_edge) return 1'b0;
        return hist[j % 64];
    endfunction

    task automatic model_step(input int i, input int k, input bit r, input bit f);
        if (rst) begin
            md[i] = M_IDLE; tref[i] = 0; m_phase[i] = 0; m_pv[i] = 0;
            m_ton[i] = 0; m_toff[i] = 0; m_per[i] = 0; m_val[i] = 0; m_err[i] = 0;
        end else begin
            m_val[i] = 0;
            if (start) begin
                tref[i] = k; m_pv[i] = 0; m_err[i] = 0; md[i] = M_WAIT;
            end else if (md[i] != M_IDLE) begin
                if (md[i] == M_WAIT && r) begin
                    m_phase[i] = k - tref[i]; m_pv[i] = 1; tref[i] = k; md[i] = M_HIGH;
                end else if (md[i] == M_HIGH && f) begin
                    m_ton[i] = k - tref[i]; tref[i] = k; md[i] = M_LOW;
                end else if (md[i] == M_LOW && r) begin
                    m_toff[i] = k - tref[i]; m_per[i] = m_ton[i] + m_toff[i];
                    m_val[i] = 1; tref[i] = k; md[i] = M_HIGH;
                end else if (k - tref[i] >= maxc[i]) begin
                    m_err[i] = 1; md[i] = M_IDLE;
                end
            end
        end
    endtask

    task automatic cmp(input int i, input int ph, input int pv, input int tn, input int tf,
                       input int pd, input int v, input int b, input int e);
        chk($sformatf("u%0d.phase", i), ph, m_phase[i]);
        chk($sformatf("u%0d.phase_vld", i), pv, m_pv[i]);
        chk($sformatf("u%0d.ton", i), tn, m_ton[i]);
        chk($sformatf("u%0d.toff", i), tf, m_toff[i]);
        chk($sformatf("u%0d.period", i), pd, m_per[i]);
        chk($sformatf("u%0d.valid", i), v, m_val[i]);
        chk($sformatf("u%0d.busy", i), b, (md[i] != M_IDLE) ? 1 : 0);
        chk($sformatf("u%0d.err", i), e, m_err[i]);
    endtask

    // Model update on each edge, then compare both instances just after it
    always @(posedge clk) begin
        bit r, f;
        cyc++;
        hist[cyc % 64] = sig_in;
        if (rst) rst_edge = cyc;
        r =  samp(cyc - N) && !samp(cyc - N - 1);
        f = !samp(cyc - N) &&  samp(cyc - N - 1);
        for (int i = 0; i < 2; i++) model_step(i, cyc, r, f);
        if (rst) chk_en = 1'b1;
        #1;
        if (chk_en) begin
            cmp(0, int'(phase16), int'(phase_vld16), int'(ton16), int'(toff16),
                int'(period16), int'(valid16), int'(busy16), int'(err16));
            cmp(1, int'(phase4), int'(phase_vld4), int'(ton4), int'(toff4),
                int'(period4), int'(valid4), int'(busy4), int'(err4));
            if (valid16) q16.push_back(cyc);
            if (phase_vld16 && !pv16_prev) pv16_edge = cyc;
            pv16_prev = phase_vld16;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // One cycle of waveform; in random mode may also pulse start or add an unsampled glitch
    task automatic wtick();
        if (rnd_mode && $urandom_range(0, 29) == 0) start = 1'b1;
        if (rnd_mode && $urandom_range(0, 9) == 0) begin
            sig_in = ~sig_in;
            #2;
            sig_in = ~sig_in;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int c = 0; c < n; c++) begin
            sig_in = 1'b1;
            repeat (hi) wtick();
            sig_in = 1'b0;
            repeat (lo) wtick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int e0;
        int n;
        rst = 1'b1; start = 1'b0; sig_in = 1'b0;
        tick(); tick();
        chk("rst_busy", int'(busy16), 0);
        chk("rst_phase", int'(phase16), 0);
        chk("rst_period", int'(period16), 0);
        chk("rst_err4", int'(err4), 0);
        rst = 1'b0;
        tick();

        // 50% duty, rise first sampled four edges after start
        pulse_start(); e0 = cyc; q16.delete();
        repeat (3) tick();
        wave(5, 5, 3);
        chk("p50_phase", int'(phase16), 6);
        chk("p50_phase_edge", pv16_edge - e0, 6);
        chk("p50_first_valid", (q16.size() > 0) ? q16[0] - e0 : -1, 16);
        chk("p50_spacing", (q16.size() > 1) ? q16[1] - q16[0] : -1, 10);
        chk("p50_ton", int'(ton16), 5);
        chk("p50_toff", int'(toff16), 5);
        chk("p50_period", int'(period16), 10);

        // 3 high / 7 low, then the 1/1 minimum
        pulse_start();
        wave(3, 7, 3);
        chk("d37_ton", int'(ton16), 3);
        chk("d37_toff", int'(toff16), 7);
        chk("d37_period", int'(period16), 10);
        q16.delete();
        wave(1, 1, 8);
        n = q16.size();
        chk("d11_ton", int'(ton16), 1);
        chk("d11_toff", int'(toff16), 1);
        chk("d11_period", int'(period16), 2);
        chk("d11_spacing", (n > 1) ? q16[n-1] - q16[n-2] : -1, 2);

        // Reset while in HIGH, then a normal measurement
        pulse_start();
        sig_in = 1'b1;
        repeat (6) tick();
        rst = 1'b1; tick(); rst = 1'b0; sig_in = 1'b0;
        chk("rsth_busy", int'(busy16), 0);
        chk("rsth_pv", int'(phase_vld16), 0);
        chk("rsth_ton", int'(ton16), 0);
        chk("rsth_phase", int'(phase16), 0);
        pulse_start();
        wave(4, 6, 3);
        chk("rsth_new_ton", int'(ton16), 4);
        chk("rsth_new_toff", int'(toff16), 6);

        // Overflow on the 4-bit instance with sig_in held low
        pulse_start(); e0 = cyc;
        repeat (14) tick();
        chk("ovf_err_before", int'(err4), 0);
        chk("ovf_busy_before", int'(busy4), 1);
        tick();
        chk("ovf_err", int'(err4), 1);
        chk("ovf_busy", int'(busy4), 0);
        chk("ovf_pv", int'(phase_vld4), 0);
        chk("ovf_busy16", int'(busy16), 1);
        pulse_start();
        chk("ovf_err_clr", int'(err4), 0);
        chk("ovf_busy_again", int'(busy4), 1);

        // Restart during LOW
        pulse_start();
        wave(4, 8, 3);
        repeat (2) tick();
        pulse_start();
        chk("rs_pv", int'(phase_vld16), 0);
        chk("rs_valid", int'(valid16), 0);
        chk("rs_ton_kept", int'(ton16), 4);
        chk("rs_toff_kept", int'(toff16), 8);
        chk("rs_period_kept", int'(period16), 12);
        wave(2, 2, 3);
        chk("rs_new_phase", int'(phase16), 3);

        // Longest period the 4-bit counters can represent
        pulse_start();
        repeat (3) tick();
        wave(15, 15, 3);
        chk("max_ton", int'(ton4), 15);
        chk("max_toff", int'(toff4), 15);
        chk("max_period", int'(period4), 30);
        chk("max_err", int'(err4), 0);

        // Randomised waveforms with stray starts, glitches and resets
        rnd_mode = 1'b1;
        repeat (40) begin
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) pulse_start();
            wave($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 4));
        end
        rnd_mode = 1'b0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
